// File: rtl/i_fetch.sv
// -----------------------------------------------------------------------------
// i_fetch -- instruction fetch unit (requesting side of the instruction ROM)
//
// Owns the PC and drives it as a word-aligned byte address into the ROM. The
// ROM answers combinationally in the same cycle. The returned word is captured
// together with its PC into a small FIFO. The FIFO head is presented to decode.
// Redirects from execute flush the FIFO and reload the PC.
//
// Handshake (decode side): a transfer happens on a rising edge where
// instr_valid and instr_ready are both 1. instr_valid never depends on
// instr_ready. While instr_valid = 1 and instr_ready = 0, instr and instr_pc
// hold. instr_valid, instr and instr_pc come from registered FIFO state only.
//
// Parameters:
//   ADDR_WIDTH  PC / ROM address width
//   DATA_WIDTH  instruction width
//   RESET_PC    PC loaded on reset
//   Q_DEPTH     fetch FIFO depth (power of two, >= 2)
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   address          byte address to ROM (= PC, low two bits always 00)
//   i_out            ROM data for address, valid in the same cycle
//   redirect_valid   one-cycle redirect request
//   redirect_pc      redirect target byte address
//   instr_valid      FIFO head valid
//   instr_ready      decode accepts the head
//   instr, instr_pc  head instruction and its byte address (0 when empty)
//   fetch_misalign   sticky misaligned-redirect flag (FETCH_MISALIGN_CHECK_EN)
//
// Build option: define FETCH_MISALIGN_CHECK_EN to add the fetch_misalign port.
// -----------------------------------------------------------------------------
module i_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    Q_DEPTH    = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] i_out,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                  fetch_misalign
`endif
);

    localparam int PW = $clog2(Q_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(Q_DEPTH);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] mem_pc    [Q_DEPTH];
    logic [DATA_WIDTH-1:0] mem_instr [Q_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;

    logic pop;
    logic space;
    logic enq;

    assign address     = pc;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? mem_instr[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? mem_pc[rd_ptr]    : '0;

    assign pop   = instr_valid & instr_ready;
    // A pop frees a slot in the same edge, so a full FIFO still fetches.
    assign space = (count < FULL) | pop;
    assign enq   = space & ~redirect_valid;

    // Storage is not reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_pc[wr_ptr]    <= pc;
            mem_instr[wr_ptr] <= i_out;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            // Flush; a head popped this cycle is still a completed transfer.
            pc     <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                pc     <= pc + ADDR_WIDTH'(4);
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_misalign <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            fetch_misalign <= 1'b1;
        end
    end
`else
    // Low target bits are dropped without any report in this build.
    logic unused_redirect_low;
    assign unused_redirect_low = ^redirect_pc[1:0];
`endif

endmodule

// File: tb/tb_i_fetch.sv
// -----------------------------------------------------------------------------
// tb_i_fetch -- bench for i_fetch (Q_DEPTH = 2).
// ROM word k holds k. A second instance starts at 0xFFFFFFF8 to cover PC wrap.
// -----------------------------------------------------------------------------
module tb_i_fetch;

    localparam int DEPTH = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic [31:0] address;
    logic [31:0] i_out;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misalign;
    logic        w_misalign;
`endif

    logic [31:0] w_address;
    logic [31:0] w_i_out;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a >> 2;
    endfunction

    assign i_out   = rom_word(address);
    assign w_i_out = rom_word(w_address);

    i_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0), .Q_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .i_out(i_out),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        , .fetch_misalign(fetch_misalign)
`endif
    );

    i_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .Q_DEPTH(DEPTH)) u_wrap (
        .clk(clk), .reset_n(reset_n), .address(w_address), .i_out(w_i_out),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .instr_valid(w_valid), .instr_ready(1'b1),
        .instr(w_instr), .instr_pc(w_instr_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        , .fetch_misalign(w_misalign)
`endif
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // ---------------- reference model / scoreboard ----------------
    // exp_q holds the PCs waiting in the fetch queue, head first; the
    // instruction at each PC is simply the ROM word for that PC.
    logic [31:0] exp_q[$];
    logic [31:0] m_pc;
    bit          m_mis;
    logic [31:0] w_exp;      // next PC the wrap instance must deliver
    bit          w_seen;     // wrap instance showed valid at the last sample
    int          delivered;

    task automatic model_reset();
        exp_q.delete();
        m_pc   = 32'h0;
        m_mis  = 1'b0;
        w_exp  = 32'hFFFF_FFF8;
        w_seen = 1'b0;
    endtask

    task automatic model_edge(input bit rdy, input bit rv, input logic [31:0] rpc);
        bit pop;
        pop = (exp_q.size() != 0) && rdy;
        if (pop) delivered++;
        if (rv) begin
            exp_q.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (rpc[1:0] != 2'b00) m_mis = 1'b1;
        end else if (exp_q.size() < DEPTH || pop) begin
            if (pop) void'(exp_q.pop_front());
            exp_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
        if (w_seen) w_exp = w_exp + 32'd4;
    endtask

    task automatic compare_all();
        bit v;
        v = (exp_q.size() != 0);
        check("instr_valid", instr_valid, v);
        check("instr_pc", instr_pc, v ? exp_q[0] : 32'h0);
        check("instr", instr, v ? rom_word(exp_q[0]) : 32'h0);
        check("address", address, m_pc);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("fetch_misalign", fetch_misalign, m_mis);
`endif
        if (w_valid) check("wrap_pc", w_instr_pc, w_exp);
        w_seen = w_valid;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rpc);
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        model_edge(rdy, rv, rpc);
        @(negedge clk);
        compare_all();
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        #2;
        reset_n        = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_address", address, 32'h0);
        check("rst_wrap_address", w_address, 32'hFFFF_FFF8);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("rst_misalign", fetch_misalign, 1'b0);
`endif
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        compare_all();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        delivered = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Streaming with decode always ready: PCs 0,4,8,... back to back.
        cycle(1, 0, 0);
        check("first_pc", instr_pc, 32'h0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0);
        check("stream_pc", instr_pc, 32'd40);

        // Backpressure straight after reset.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(0, 0, 0);
        check("stall_address", address, 32'h8);
        check("stall_head", instr_pc, 32'h0);
        for (int i = 0; i < 6; i++) cycle(1, 0, 0);

        // Redirect while the queue holds 0x8 and 0xC.
        do_reset();
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        check("pre_redirect_head", instr_pc, 32'h8);
        cycle(0, 1, 32'h40);
        check("flushed", instr_valid, 1'b0);
        check("redirect_address", address, 32'h40);
        cycle(1, 0, 0);
        check("target_head", instr_pc, 32'h40);
        cycle(1, 0, 0);
        check("target_next", instr_pc, 32'h44);

        // Redirect in the same cycle as the pop of 0x4.
        do_reset();
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        check("head_4", instr_pc, 32'h4);
        cycle(1, 1, 32'h80);
        cycle(1, 0, 0);
        check("after_pop_redirect", instr_pc, 32'h80);

        // Misaligned redirect target.
        cycle(1, 1, 32'h22);
        cycle(1, 0, 0);
        check("aligned_target", instr_pc, 32'h20);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0);

        // Randomized traffic, with an asynchronous reset mid-stream.
        for (int i = 0; i < 400; i++) begin
            bit          rdy;
            bit          rv;
            logic [31:0] rpc;
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 9) == 0);
            rpc = $urandom();
            if ($urandom_range(0, 1) == 1) rpc = rpc & 32'h0000_0FFF;
            if (i == 200) do_reset();
            else cycle(rdy, rv, rpc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
